// File: rtl/step_pulse_gen_pkg.sv
// Shared types and default parameters for the single-step push-button conditioner.
package step_pkg;

    typedef enum logic [1:0] {S_IDLE, S_ARM_HI, S_HELD, S_ARM_LO} step_state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int unsigned PULSE_CYCLES_DEF    = 4;
    localparam int unsigned REPEAT_DELAY_DEF    = 25000000;
    localparam int unsigned REPEAT_PERIOD_DEF   = 10000000;
    localparam int unsigned STEP_COUNT_W        = 16;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/step_pulse_gen_if.sv
// Key input and conditioned step outputs between the board top and step_pulse_gen.
interface step_pulse_gen_if;
    import step_pkg::*;

    logic                    KeyRaw;
    logic                    Level;
    logic                    Strobe;
    logic                    StepClk;
    logic [STEP_COUNT_W-1:0] StepCount;

    modport master (input KeyRaw, output Level, output Strobe, output StepClk, output StepCount);
    modport slave  (output KeyRaw, input Level, input Strobe, input StepClk, input StepCount);

endinterface

// File: rtl/step_pulse_gen_sync2.sv
// Two-flop synchronizer for asynchronous level inputs (keys, switches).
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/step_pulse_gen.sv
// Debounces the step key and produces press strobe, stretched StepClk and a step count.
// Optional auto-repeat while held is enabled by defining AUTO_REPEAT_EN.
module step_pulse_gen
    import step_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned PULSE_CYCLES    = PULSE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    step_pulse_gen_if.master bus
);

    localparam int unsigned MAX_PARAM = max2(max2(DEBOUNCE_CYCLES, PULSE_CYCLES),
                                             max2(REPEAT_DELAY, REPEAT_PERIOD));
    localparam int unsigned CNT_W     = $clog2(MAX_PARAM) + 1;

    step_state_t             state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [CNT_W-1:0]        pcnt, pcnt_n;
    logic                    ks;
    logic                    accept;
    logic                    rep_tick;
    logic                    strobe_n;
    logic                    level;
    logic                    strobe;
    logic                    step_clk;
    logic [STEP_COUNT_W-1:0] step_count;

    sync2 u_sync (
        .clk (Clk),
        .rst (Reset),
        .d   (bus.KeyRaw),
        .q   (ks)
    );

    // Debounce FSM: cnt tracks consecutive samples agreeing with the candidate level
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        case (state)
            S_IDLE: begin
                if (ks) begin
                    state_n = S_ARM_HI;
                    cnt_n   = CNT_W'(1);
                end
            end
            S_ARM_HI: begin
                if (!ks) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_n = S_HELD;
                    cnt_n   = '0;
                    accept  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_HELD: begin
                if (!ks) begin
                    state_n = S_ARM_LO;
                    cnt_n   = CNT_W'(1);
                end
            end
            S_ARM_LO: begin
                if (ks) begin
                    state_n = S_HELD;
                    cnt_n   = '0;
                end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

`ifdef AUTO_REPEAT_EN
    logic [CNT_W-1:0] rcnt, rcnt_n, rcnt_inc, rep_limit;
    logic             rphase, rphase_n;

    // rcnt pauses in S_ARM_LO; a release bounce (ks=0 in S_HELD) never ticks
    always_comb begin
        rcnt_n    = rcnt;
        rphase_n  = rphase;
        rep_tick  = 1'b0;
        rcnt_inc  = rcnt + CNT_W'(1);
        rep_limit = rphase ? CNT_W'(REPEAT_PERIOD) : CNT_W'(REPEAT_DELAY);
        if (state_n == S_IDLE || state_n == S_ARM_HI) begin
            rcnt_n   = '0;
            rphase_n = 1'b0;
        end else if (state == S_HELD && ks) begin
            if (rcnt_inc == rep_limit) begin
                rep_tick = 1'b1;
                rcnt_n   = '0;
                rphase_n = 1'b1;
            end else begin
                rcnt_n = rcnt_inc;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rcnt   <= '0;
            rphase <= 1'b0;
        end else begin
            rcnt   <= rcnt_n;
            rphase <= rphase_n;
        end
    end
`else
    assign rep_tick = 1'b0;
`endif

    assign strobe_n = accept | rep_tick;

    // A new strobe reloads the stretcher so overlapping steps merge into one pulse
    always_comb begin
        pcnt_n = pcnt;
        if (strobe_n) begin
            pcnt_n = CNT_W'(PULSE_CYCLES);
        end else if (pcnt != '0) begin
            pcnt_n = pcnt - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            pcnt       <= '0;
            level      <= 1'b0;
            strobe     <= 1'b0;
            step_clk   <= 1'b0;
            step_count <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pcnt     <= pcnt_n;
            level    <= (state_n == S_HELD) || (state_n == S_ARM_LO);
            strobe   <= strobe_n;
            step_clk <= (pcnt_n != '0);
            if (strobe_n) begin
                step_count <= step_count + STEP_COUNT_W'(1);
            end
        end
    end

    assign bus.Level     = level;
    assign bus.Strobe    = strobe;
    assign bus.StepClk   = step_clk;
    assign bus.StepCount = step_count;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed, table-driven bench for step_pulse_gen with small debounce/pulse parameters.
module tb_step_pulse_gen;

    localparam int unsigned D  = 4;
    localparam int unsigned P  = 2;
    localparam int unsigned RD = 20;
    localparam int unsigned RP = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [15:0] exp_count;

    step_pulse_gen_if bus ();

    step_pulse_gen #(
        .DEBOUNCE_CYCLES (D),
        .PULSE_CYCLES    (P),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] keys;
        int          strobes;
        int          clk_hi;
        logic        level20;
        logic        level_end;
    } vec_t;

    vec_t vecs[6];

    // Applies one 32-cycle key pattern (bit c drives cycle c), then 8 idle cycles
    task automatic run_pattern(input logic [31:0] keys, output int ns, output int nh,
                               output logic lvl20);
        ns    = 0;
        nh    = 0;
        lvl20 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            bus.KeyRaw = (c < 32) ? keys[c] : 1'b0;
            @(negedge clk);
            ns += int'(bus.Strobe);
            nh += int'(bus.StepClk);
            if (c == 20) lvl20 = bus.Level;
        end
    endtask

    initial begin
        int   ns, nh;
        logic lvl20;
        checks    = 0;
        failures  = 0;
        exp_count = 16'h0000;

        vecs[0] = '{32'h000F_FFFF, 1, 2, 1'b1, 1'b0};
        vecs[1] = '{32'h0000_0005, 0, 0, 1'b0, 1'b0};
        vecs[2] = '{32'h00FF_CFFF, 1, 2, 1'b1, 1'b0};
        vecs[3] = '{32'h0000_0007, 0, 0, 1'b0, 1'b0};
        vecs[4] = '{32'h0000_000F, 1, 2, 1'b0, 1'b0};
        vecs[5] = '{32'h00FF_00FF, 2, 4, 1'b0, 1'b0};

        rst        = 1'b1;
        bus.KeyRaw = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_level",   32'(bus.Level),     32'h0);
        check("reset_strobe",  32'(bus.Strobe),    32'h0);
        check("reset_stepclk", 32'(bus.StepClk),   32'h0);
        check("reset_count",   32'(bus.StepCount), 32'h0);
        rst = 1'b0;

        // Press latency: strobe appears after the 6th edge following the key rise
        @(negedge clk);
        bus.KeyRaw = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            check("latency_pre_strobe", 32'(bus.Strobe), 32'h0);
        end
        @(negedge clk);
        check("latency_strobe",  32'(bus.Strobe),    32'h1);
        check("latency_stepclk", 32'(bus.StepClk),   32'h1);
        check("latency_level",   32'(bus.Level),     32'h1);
        check("latency_count",   32'(bus.StepCount), 32'h1);
        @(negedge clk);
        check("strobe_one_cycle", 32'(bus.Strobe),  32'h0);
        check("stepclk_held",     32'(bus.StepClk), 32'h1);

        // Asynchronous reset in the middle of the StepClk pulse
        rst = 1'b1;
        #1;
        check("midpulse_level",   32'(bus.Level),     32'h0);
        check("midpulse_strobe",  32'(bus.Strobe),    32'h0);
        check("midpulse_stepclk", 32'(bus.StepClk),   32'h0);
        check("midpulse_count",   32'(bus.StepCount), 32'h0);
        bus.KeyRaw = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("post_reset_count", 32'(bus.StepCount), 32'h0);
        check("post_reset_level", 32'(bus.Level),     32'h0);

        for (int v = 0; v < 6; v++) begin
            run_pattern(vecs[v].keys, ns, nh, lvl20);
            exp_count = exp_count + 16'(vecs[v].strobes);
            check($sformatf("vec%0d_strobes", v), 32'(ns), 32'(vecs[v].strobes));
            check($sformatf("vec%0d_stepclk_cycles", v), 32'(nh), 32'(vecs[v].clk_hi));
            check($sformatf("vec%0d_count", v), 32'(bus.StepCount), 32'(exp_count));
            check($sformatf("vec%0d_level_mid", v), 32'(lvl20), 32'(vecs[v].level20));
            check($sformatf("vec%0d_level_end", v), 32'(bus.Level), 32'(vecs[v].level_end));
        end

        // Counter wrap from all-ones on the next press
        @(negedge clk);
        force dut.step_count = 16'hFFFF;
        @(negedge clk);
        release dut.step_count;
        @(negedge clk);
        check("wrap_preload", 32'(bus.StepCount), 32'h0000_FFFF);
        run_pattern(32'h0000_00FF, ns, nh, lvl20);
        check("wrap_strobes", 32'(ns), 32'h1);
        check("wrap_count",   32'(bus.StepCount), 32'h0);

`ifdef AUTO_REPEAT_EN
        begin
            int idx[$];
            logic [15:0] base;
            base = bus.StepCount;
            for (int c = 0; c < 60; c++) begin
                bus.KeyRaw = (c < 46) ? 1'b1 : 1'b0;
                @(negedge clk);
                if (bus.Strobe) idx.push_back(c);
            end
            check("repeat_strobes", 32'(idx.size()), 32'h4);
            check("repeat_count", 32'(bus.StepCount - base), 32'h4);
            if (idx.size() == 4) begin
                check("repeat_first_gap",  32'(idx[1] - idx[0]), 32'(RD));
                check("repeat_second_gap", 32'(idx[2] - idx[1]), 32'(RP));
                check("repeat_third_gap",  32'(idx[3] - idx[2]), 32'(RP));
            end
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
